// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one flash->PSRAM DMA engine between requesters A and B (optional DMA_TIMEOUT_EN abort).
// Latency: ack 1 cycle after req is seen in IDLE; dma_start 1 cycle after ack; done 1 cycle after dma_busy falls.
// Backpressure: req is level-held until ack; the other requester waits until the arbiter is back in IDLE.
`timescale 1ns/1ps
module dma_arbiter #(
    parameter int unsigned START_WAIT     = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd3200000
) (
    input  logic        clk32,
    input  logic        resn,
    input  logic        a_req,
    input  logic [23:0] a_src,
    input  logic [21:0] a_dst,
    input  logic [15:0] a_len,
    input  logic        b_req,
    input  logic [23:0] b_src,
    input  logic [21:0] b_dst,
    input  logic [15:0] b_len,
    output logic        a_ack,
    output logic        b_ack,
    output logic        a_done,
    output logic        b_done,
    output logic        a_err,
    output logic        b_err,
    output logic [23:0] dma_flash_src_addr,
    output logic [21:0] dma_psram_dst_addr,
    output logic [15:0] dma_data_length,
    output logic        dma_start,
    input  logic        dma_busy,
    output logic        owner,
    output logic        arb_busy,
    output logic        timeout_flag
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, DRAIN} state_t;

    localparam int WW = (START_WAIT > 1) ? $clog2(START_WAIT + 1) : 1;

    state_t          state;
    logic            last_grant;
    logic [WW-1:0]   wcnt;
    logic            pick_b;

    // On a tie, serve whoever was not granted last.
    assign pick_b   = b_req && (!a_req || !last_grant);
    assign arb_busy = (state != IDLE);

`ifdef DMA_TIMEOUT_EN
    logic [23:0] tcnt;
`else
    logic [23:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign a_err          = 1'b0;
    assign b_err          = 1'b0;
    assign timeout_flag   = 1'b0;
`endif

    always_ff @(posedge clk32 or negedge resn) begin
        if (!resn) begin
            state              <= IDLE;
            last_grant         <= 1'b1;
            wcnt               <= '0;
            owner              <= 1'b0;
            a_ack              <= 1'b0;
            b_ack              <= 1'b0;
            a_done             <= 1'b0;
            b_done             <= 1'b0;
            dma_start          <= 1'b0;
            dma_flash_src_addr <= '0;
            dma_psram_dst_addr <= '0;
            dma_data_length    <= '0;
`ifdef DMA_TIMEOUT_EN
            tcnt               <= '0;
            a_err              <= 1'b0;
            b_err              <= 1'b0;
            timeout_flag       <= 1'b0;
`endif
        end else begin
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            dma_start <= 1'b0;
`ifdef DMA_TIMEOUT_EN
            a_err     <= 1'b0;
            b_err     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        if (pick_b) begin
                            dma_flash_src_addr <= b_src;
                            dma_psram_dst_addr <= b_dst;
                            dma_data_length    <= b_len;
                            b_ack              <= 1'b1;
                        end else begin
                            dma_flash_src_addr <= a_src;
                            dma_psram_dst_addr <= a_dst;
                            dma_data_length    <= a_len;
                            a_ack              <= 1'b1;
                        end
                        owner      <= pick_b;
                        last_grant <= pick_b;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A zero-length descriptor completes without touching the engine.
                    if (dma_data_length == 16'd0) begin
                        a_done <= !owner;
                        b_done <= owner;
                        state  <= IDLE;
                    end else begin
                        dma_start <= 1'b1;
                        wcnt      <= '0;
                        state     <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (dma_busy) begin
`ifdef DMA_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                        state <= RUN;
                    end else if (wcnt == WW'(START_WAIT - 1)) begin
                        // Busy never seen: the copy was short enough to finish unobserved.
                        a_done <= !owner;
                        b_done <= owner;
                        state  <= IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!dma_busy) begin
                        a_done <= !owner;
                        b_done <= owner;
                        state  <= IDLE;
                    end
`ifdef DMA_TIMEOUT_EN
                    else if (tcnt == TIMEOUT_CYCLES - 24'd1) begin
                        a_err        <= !owner;
                        b_err        <= owner;
                        a_done       <= !owner;
                        b_done       <= owner;
                        timeout_flag <= 1'b1;
                        state        <= DRAIN;
                    end else begin
                        tcnt <= tcnt + 24'd1;
                    end
`endif
                end
`ifdef DMA_TIMEOUT_EN
                DRAIN: begin
                    // Engine still owns PSRAM; hold off new grants until it lets go.
                    if (!dma_busy) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Scoreboarded bench for dma_arbiter: expected grants queued at stimulus time, checked on ack and dma_start.
// Includes the timeout scenario when DMA_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_dma_arbiter;

    localparam int START_WAIT = 4;
`ifdef DMA_TIMEOUT_EN
    localparam logic [23:0] TO_CYC = 24'd100;
`else
    localparam logic [23:0] TO_CYC = 24'd3200000;
`endif

    logic        clk32, resn;
    logic        a_req, b_req;
    logic [23:0] a_src, b_src;
    logic [21:0] a_dst, b_dst;
    logic [15:0] a_len, b_len;
    logic        a_ack, b_ack, a_done, b_done, a_err, b_err;
    logic [23:0] dma_flash_src_addr;
    logic [21:0] dma_psram_dst_addr;
    logic [15:0] dma_data_length;
    logic        dma_start, dma_busy, owner, arb_busy, timeout_flag;

    dma_arbiter #(.START_WAIT(START_WAIT), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk32(clk32), .resn(resn),
        .a_req(a_req), .a_src(a_src), .a_dst(a_dst), .a_len(a_len),
        .b_req(b_req), .b_src(b_src), .b_dst(b_dst), .b_len(b_len),
        .a_ack(a_ack), .b_ack(b_ack), .a_done(a_done), .b_done(b_done),
        .a_err(a_err), .b_err(b_err),
        .dma_flash_src_addr(dma_flash_src_addr), .dma_psram_dst_addr(dma_psram_dst_addr),
        .dma_data_length(dma_data_length), .dma_start(dma_start), .dma_busy(dma_busy),
        .owner(owner), .arb_busy(arb_busy), .timeout_flag(timeout_flag)
    );

    typedef struct {
        logic        who;
        logic [23:0] src;
        logic [21:0] dst;
        logic [15:0] len;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0;
    int   n_ack = 0, n_start = 0, n_a_done = 0, n_b_done = 0, n_err = 0;
    int   start_cyc = 0, busy_fall_cyc = 0;
    int   eng_cycles = 20;
    bit   eng_never = 0, eng_abort = 0;

    initial begin
        clk32 = 0;
        forever #5 clk32 = ~clk32;
    end

    always @(posedge clk32) cyc <= cyc + 1;

    // Behavioural engine: busy rises right after dma_start and stays up eng_cycles cycles.
    initial begin
        dma_busy = 0;
        forever begin
            @(posedge clk32); #1;
            if (dma_start && !eng_never) begin
                dma_busy = 1;
                for (int i = 0; i < eng_cycles && !eng_abort; i++) begin
                    @(posedge clk32); #1;
                end
                dma_busy      = 0;
                busy_fall_cyc = cyc;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk32) begin
        exp_t e;
        if (a_ack || b_ack) begin
            n_ack++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ack_unexpected got a_ack=%b b_ack=%b with no grant expected", a_ack, b_ack);
            end else begin
                e = exp_q.pop_front();
                cur = e;
                if ({a_ack, b_ack, owner, dma_flash_src_addr, dma_psram_dst_addr, dma_data_length} !==
                    {!e.who, e.who, e.who, e.src, e.dst, e.len}) begin
                    n_fail++;
                    $display("FAIL ack_grant got b=%b owner=%b %h/%h/%h exp b=%b %h/%h/%h", b_ack, owner,
                             dma_flash_src_addr, dma_psram_dst_addr, dma_data_length,
                             e.who, e.src, e.dst, e.len);
                end
            end
        end
        if (dma_start) begin
            n_start++;
            start_cyc = cyc;
            n_checks++;
            if ({dma_flash_src_addr, dma_psram_dst_addr, dma_data_length} !== {cur.src, cur.dst, cur.len}) begin
                n_fail++;
                $display("FAIL start_desc got %h/%h/%h exp %h/%h/%h", dma_flash_src_addr, dma_psram_dst_addr,
                         dma_data_length, cur.src, cur.dst, cur.len);
            end
        end
        if (a_done) n_a_done++;
        if (b_done) n_b_done++;
        if (a_err || b_err) n_err++;
    end

    task automatic push_exp(input logic who, input logic [23:0] s, input logic [21:0] d, input logic [15:0] l);
        exp_t e;
        e.who = who; e.src = s; e.dst = d; e.len = l;
        exp_q.push_back(e);
    endtask

    // kind: 0 a_ack, 1 b_ack, 2 a_done, 3 b_done, 4 any err. at = -1 when the budget runs out.
    task automatic wait_evt(input int kind, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk32);
            if ((kind == 0 && a_ack) || (kind == 1 && b_ack) || (kind == 2 && a_done) ||
                (kind == 3 && b_done) || (kind == 4 && (a_err || b_err))) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic drive_a(input logic [23:0] s, input logic [21:0] d, input logic [15:0] l, output int ta);
        a_src = s; a_dst = d; a_len = l; a_req = 1;
        wait_evt(0, 300, ta);
        a_req = 0;
    endtask

    task automatic drive_b(input logic [23:0] s, input logic [21:0] d, input logic [15:0] l, output int tb);
        b_src = s; b_dst = d; b_len = l; b_req = 1;
        wait_evt(1, 300, tb);
        b_req = 0;
    endtask

    task automatic test_reset();
        resn = 0;
        repeat (3) @(negedge clk32);
        n_checks++;
        if ({a_ack, b_ack, a_done, b_done, a_err, b_err, dma_start, owner, arb_busy, timeout_flag} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 0", {a_ack, b_ack, a_done, b_done, a_err, b_err,
                     dma_start, owner, arb_busy, timeout_flag});
        end
        n_checks++;
        if ({dma_flash_src_addr, dma_psram_dst_addr, dma_data_length} !== 62'b0) begin
            n_fail++;
            $display("FAIL reset_dma got %h/%h/%h exp 0", dma_flash_src_addr, dma_psram_dst_addr, dma_data_length);
        end
        resn = 1;
        @(negedge clk32);
    endtask

    task automatic test_a_only();
        int ta, td, s0;
        eng_cycles = 20;
        s0 = n_start;
        push_exp(1'b0, 24'h000000, 22'h001000, 16'h1000);
        drive_a(24'h000000, 22'h001000, 16'h1000, ta);
        wait_evt(2, 80, td);
        n_checks++;
        if (start_cyc !== ta + 1) begin
            n_fail++; $display("FAIL a_only_start_lat got %0d exp %0d", start_cyc, ta + 1);
        end
        n_checks++;
        if (n_start - s0 !== 1) begin
            n_fail++; $display("FAIL a_only_start_count got %0d exp 1", n_start - s0);
        end
        n_checks++;
        if (td !== busy_fall_cyc + 1) begin
            n_fail++; $display("FAIL a_only_done_lat got %0d exp %0d", td, busy_fall_cyc + 1);
        end
        n_checks++;
        if ({arb_busy, dma_psram_dst_addr} !== {1'b0, 22'h001000}) begin
            n_fail++; $display("FAIL a_only_idle_hold got busy=%b dst=%h exp busy=0 dst=001000", arb_busy, dma_psram_dst_addr);
        end
    endtask

    task automatic test_round_robin();
        int ta, tb, td;
        resn = 0; @(negedge clk32); resn = 1; @(negedge clk32);
        eng_cycles = 5;
        push_exp(1'b0, 24'h000400, 22'h002000, 16'h0100);
        push_exp(1'b1, 24'h001000, 22'h00F800, 16'h0800);
        a_src = 24'h000400; a_dst = 22'h002000; a_len = 16'h0100;
        b_src = 24'h001000; b_dst = 22'h00F800; b_len = 16'h0800;
        a_req = 1; b_req = 1;
        fork
            begin wait_evt(0, 100, ta); a_req = 0; end
            begin wait_evt(1, 100, tb); b_req = 0; end
        join
        wait_evt(3, 100, td);
        n_checks++;
        if (!(ta > 0 && tb > ta)) begin
            n_fail++; $display("FAIL rr_order got a_ack@%0d b_ack@%0d exp a before b", ta, tb);
        end
        n_checks++;
        if ({td > 0, dma_data_length} !== {1'b1, 16'h0800}) begin
            n_fail++; $display("FAIL rr_b_done got done@%0d len=%h exp done len=0800", td, dma_data_length);
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        eng_cycles = 3;
        a0 = n_ack;
        push_exp(1'b0, 24'h00A000, 22'h000A00, 16'h0010);
        push_exp(1'b1, 24'h00B000, 22'h000B00, 16'h0020);
        push_exp(1'b0, 24'h00A000, 22'h000A00, 16'h0010);
        push_exp(1'b1, 24'h00B000, 22'h000B00, 16'h0020);
        a_src = 24'h00A000; a_dst = 22'h000A00; a_len = 16'h0010;
        b_src = 24'h00B000; b_dst = 22'h000B00; b_len = 16'h0020;
        a_req = 1; b_req = 1;
        for (int i = 0; i < 300 && n_ack < a0 + 4; i++) begin @(negedge clk32); #1; end
        a_req = 0; b_req = 0;
        repeat (40) @(negedge clk32);
        n_checks++;
        if ({exp_q.size() == 0, arb_busy} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_alternate got pending=%0d busy=%b exp 0/0", exp_q.size(), arb_busy);
        end
        a0 = n_ack;
        push_exp(1'b0, 24'h00A000, 22'h000A00, 16'h0010);
        push_exp(1'b0, 24'h00A000, 22'h000A00, 16'h0010);
        a_req = 1;
        for (int i = 0; i < 300 && n_ack < a0 + 2; i++) begin @(negedge clk32); #1; end
        a_req = 0;
        repeat (40) @(negedge clk32);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL b2b_lone got pending=%0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_zero_len();
        int tk, td, s0;
        s0 = n_start;
        push_exp(1'b1, 24'h003000, 22'h000100, 16'h0000);
        drive_b(24'h003000, 22'h000100, 16'h0000, tk);
        wait_evt(3, 10, td);
        n_checks++;
        if (td !== tk + 1) begin
            n_fail++; $display("FAIL zero_len_done got %0d exp %0d", td, tk + 1);
        end
        repeat (10) @(negedge clk32);
        n_checks++;
        if (n_start !== s0) begin
            n_fail++; $display("FAIL zero_len_no_start got %0d starts exp 0", n_start - s0);
        end
    endtask

    task automatic test_no_busy();
        int ta, td;
        eng_never = 1;
        push_exp(1'b0, 24'h005000, 22'h000300, 16'h0020);
        drive_a(24'h005000, 22'h000300, 16'h0020, ta);
        wait_evt(2, 20, td);
        n_checks++;
        if ({start_cyc, td} !== {ta + 1, ta + 1 + START_WAIT}) begin
            n_fail++; $display("FAIL no_busy_done got start@%0d done@%0d exp %0d/%0d", start_cyc, td,
                               ta + 1, ta + 1 + START_WAIT);
        end
        @(negedge clk32);
        n_checks++;
        if ({arb_busy, a_done} !== 2'b00) begin
            n_fail++; $display("FAIL no_busy_idle got busy=%b done=%b exp 0/0", arb_busy, a_done);
        end
        eng_never = 0;
    endtask

    task automatic test_reset_run();
        int ta, td, d0;
        eng_cycles = 60;
        d0 = n_a_done;
        push_exp(1'b0, 24'h000100, 22'h000200, 16'h0400);
        drive_a(24'h000100, 22'h000200, 16'h0400, ta);
        repeat (6) @(negedge clk32);
        n_checks++;
        if ({arb_busy, dma_busy} !== 2'b11) begin
            n_fail++; $display("FAIL rst_run_pre got busy=%b dma_busy=%b exp 1/1", arb_busy, dma_busy);
        end
        resn = 0; eng_abort = 1;
        #1;
        n_checks++;
        if ({a_ack, b_ack, a_done, b_done, dma_start, owner, arb_busy, timeout_flag,
             dma_flash_src_addr, dma_psram_dst_addr, dma_data_length} !== 70'b0) begin
            n_fail++; $display("FAIL rst_run_outputs got busy=%b src=%h len=%h exp all 0", arb_busy,
                               dma_flash_src_addr, dma_data_length);
        end
        repeat (3) @(negedge clk32);
        resn = 1;
        repeat (2) @(negedge clk32);
        eng_abort = 0;
        repeat (20) @(negedge clk32);
        n_checks++;
        if (n_a_done !== d0) begin
            n_fail++; $display("FAIL rst_run_no_done got %0d dones exp 0", n_a_done - d0);
        end
        eng_cycles = 5;
        push_exp(1'b0, 24'h0ABCDE, 22'h012345, 16'h0030);
        drive_a(24'h0ABCDE, 22'h012345, 16'h0030, ta);
        wait_evt(2, 60, td);
        n_checks++;
        if ({td, dma_data_length} !== {busy_fall_cyc + 1, 16'h0030}) begin
            n_fail++; $display("FAIL rst_run_fresh got done@%0d len=%h exp %0d/0030", td, dma_data_length,
                               busy_fall_cyc + 1);
        end
    endtask

`ifdef DMA_TIMEOUT_EN
    task automatic test_timeout();
        int ta, te, tb, td;
        eng_cycles = 150;
        push_exp(1'b0, 24'h007000, 22'h000700, 16'h0700);
        push_exp(1'b1, 24'h008000, 22'h000800, 16'h0080);
        drive_a(24'h007000, 22'h000700, 16'h0700, ta);
        b_src = 24'h008000; b_dst = 22'h000800; b_len = 16'h0080; b_req = 1;
        wait_evt(4, 250, te);
        // RUN begins the cycle after dma_start; cycle 100 of RUN ends with the abort registered.
        n_checks++;
        if ({te, a_err, a_done, b_err} !== {ta + 1 + 101, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL timeout_err got @%0d err=%b done=%b exp @%0d err=1 done=1", te, a_err,
                               a_done, ta + 102);
        end
        @(negedge clk32);
        n_checks++;
        if (timeout_flag !== 1'b1) begin
            n_fail++; $display("FAIL timeout_flag got %b exp 1", timeout_flag);
        end
        wait_evt(1, 250, tb);
        b_req = 0;
        n_checks++;
        if (tb !== busy_fall_cyc + 2) begin
            n_fail++; $display("FAIL timeout_drain got b_ack@%0d exp %0d", tb, busy_fall_cyc + 2);
        end
        eng_cycles = 5;
        wait_evt(3, 60, td);
        n_checks++;
        if ({td > 0, timeout_flag} !== 2'b11) begin
            n_fail++; $display("FAIL timeout_b_done got done@%0d flag=%b exp done flag=1", td, timeout_flag);
        end
    endtask
`else
    task automatic test_no_timeout();
        n_checks++;
        if ({n_err, timeout_flag} !== {32'd0, 1'b0}) begin
            n_fail++; $display("FAIL no_timeout got errs=%0d flag=%b exp 0/0", n_err, timeout_flag);
        end
    endtask
`endif

    initial begin
        resn = 0; a_req = 0; b_req = 0;
        a_src = '0; a_dst = '0; a_len = '0;
        b_src = '0; b_dst = '0; b_len = '0;
        cur.who = 0; cur.src = '0; cur.dst = '0; cur.len = '0;
        test_reset();
        test_a_only();
        test_round_robin();
        test_back_to_back();
        test_zero_len();
        test_no_busy();
        test_reset_run();
`ifdef DMA_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (5) @(negedge clk32);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_drain got %0d grants outstanding exp 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no completion by %0t exp finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
